jk_cmd_sequencer: RTL

- Command-driven stimulus stage that sits directly upstream of a JK flip-flop and drives its `j`/`k` inputs.
- Accepts {operation, run-length} commands over a valid/ready handshake and buffers them in a small FIFO.
- Plays each command out as a constant `j`/`k` pair for `len+1` cycles.
- Runs a cycle-accurate model of the downstream flop (`q_exp`). Optionally checks that model against the flop's actual `q`.

---
 rtl/jk_cmd_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/jk_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// jk_cmd_sequencer
//
// Command-driven stimulus stage for a downstream JK flip-flop. Commands of the
// form {op, len} arrive over a valid/ready handshake and are queued in a small
// FIFO. An executor plays each command out as a constant {j,k} pair for len+1
// cycles, and loads queued commands back-to-back with no idle bubble.
// A cycle-accurate model of the downstream flop is kept in q_exp.
//
// Optional feature macro: JK_CHECK_EN
//   When defined, the ports q_in and mismatch exist. The actual flop output
//   q_in is compared against q_exp on every edge outside reset, and any
//   difference sets the sticky mismatch flag (cleared only by rst).
//   When undefined, both ports and the compare logic are absent.
// -----------------------------------------------------------------------------
module jk_cmd_sequencer #(
    parameter int LEN_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             q_exp
`ifdef JK_CHECK_EN
    ,
    input  logic             q_in,
    output logic             mismatch
`endif
);

    // DEPTH is expected to be a power of two so the pointers wrap naturally.
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 2 + LEN_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head_entry;
    logic [1:0]         head_op;
    logic [LEN_W-1:0]   head_len;

    // ------------------------------------------------------------------
    // Executor and model state
    // ------------------------------------------------------------------
    state_t             state_reg;
    logic [LEN_W-1:0]   cnt_reg;
    logic               j_reg;
    logic               k_reg;
    logic               q_exp_reg;

    assign fifo_full  = (count_reg == CNT_W'(DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign cmd_ready  = ~fifo_full;

    // A handshake coinciding with reset is ignored: pointers and count are
    // held in reset regardless of push.
    assign push = cmd_valid && cmd_ready;

    // The executor pops whenever it is free to start a command: either idle,
    // or on the last cycle of the current run (back-to-back reload). In IDLE
    // cnt_reg is always zero, so the same condition covers both states.
    assign pop = ~fifo_empty && ((state_reg == ST_IDLE) || (cnt_reg == '0));

    // The head entry is read asynchronously so that a pop and the load of the
    // popped command happen on the same edge; the FIFO is small enough to live
    // in distributed storage.
    assign head_entry = fifo_mem[rd_ptr_reg];
    assign head_op    = head_entry[ENTRY_W-1:LEN_W];
    assign head_len   = head_entry[LEN_W-1:0];

    // FIFO storage write; contents need no reset since the count gates reads.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr_reg] <= {cmd_op, cmd_len};
        end
    end

    // FIFO pointers and occupancy count; push+pop together keep the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Executor FSM: loads commands, counts the run down, drives registered j/k.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            j_reg     <= 1'b0;
            k_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {j_reg, k_reg} <= head_op;
                        cnt_reg        <= head_len;
                        state_reg      <= ST_RUN;
                    end else begin
                        {j_reg, k_reg} <= 2'b00;
                    end
                end
                ST_RUN: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - LEN_W'(1);
                    end else if (!fifo_empty) begin
                        // Last cycle of this run: reload immediately.
                        {j_reg, k_reg} <= head_op;
                        cnt_reg        <= head_len;
                    end else begin
                        {j_reg, k_reg} <= 2'b00;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Flop model: samples the registered j/k exactly as the real flop does.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_exp_reg <= 1'b0;
        end else begin
            case ({j_reg, k_reg})
                2'b01:   q_exp_reg <= 1'b0;
                2'b10:   q_exp_reg <= 1'b1;
                2'b11:   q_exp_reg <= ~q_exp_reg;
                default: q_exp_reg <= q_exp_reg;
            endcase
        end
    end

`ifdef JK_CHECK_EN
    logic mismatch_reg;

    // Sticky compare of the real flop against the model; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_reg <= 1'b0;
        end else if (q_in != q_exp_reg) begin
            mismatch_reg <= 1'b1;
        end
    end

    assign mismatch = mismatch_reg;
`endif

    assign j     = j_reg;
    assign k     = k_reg;
    assign q_exp = q_exp_reg;
    // Derived only from registered state, never from cmd_valid.
    assign busy  = (state_reg == ST_RUN) || ~fifo_empty;

endmodule
